// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_pkg
//  Description : Shared types for the traffic light sequencer: phase
//                encoding and the phase-to-lamp decode function.
//  Contents    : tl_state_e  - 2-bit phase encoding (RED=0, GREEN=1,
//                              YELLOW=2, 3 is unreachable in normal use)
//                tl_lamps_t  - {red, yellow, green} lamp bundle
//                lamp_decode - phase -> lamps, anything unknown shows red
//  Revision    : 1.0 - initial release
// ============================================================================
package tl_pkg;

    typedef enum logic [1:0] {
        ST_RED     = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_ILLEGAL = 2'd3
    } tl_state_e;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } tl_lamps_t;

    // Fail-safe decode: an unknown phase lights red, never green.
    function automatic tl_lamps_t lamp_decode(input tl_state_e s);
        tl_lamps_t l;
        l = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
        case (s)
            ST_GREEN:  l = '{red: 1'b0, yellow: 1'b0, green: 1'b1};
            ST_YELLOW: l = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
            default:   l = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : traffic_light_sequencer_if
//  Description : Control and status bundle of the traffic light sequencer.
//  Signals     : en        run enable (0 freezes divider and phase timer)
//                ped_req   pedestrian request, level or pulse
//                ped_ack   1-cycle pulse when a pending request is served
//                red/yellow/green  lamp drives, exactly one high
//                state     current phase (tl_pkg encoding)
//                remain    ticks left in the current phase, counts N..1
//                sec_tick  1-cycle strobe once per second
//  Modports    : master - controller side (drives en/ped_req)
//                slave  - sequencer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface traffic_light_sequencer_if #(
    parameter int CNT_W = 8
) ();
    logic             en;
    logic             ped_req;
    logic             ped_ack;
    logic             red;
    logic             yellow;
    logic             green;
    logic [1:0]       state;
    logic [CNT_W-1:0] remain;
    logic             sec_tick;

    modport master (
        output en, ped_req,
        input  ped_ack, red, yellow, green, state, remain, sec_tick
    );

    modport slave (
        input  en, ped_req,
        output ped_ack, red, yellow, green, state, remain, sec_tick
    );
endinterface
`default_nettype wire

// File: rtl/traffic_light_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Enable-pulse divider. Counts 0..TICK_DIV-1 while en=1 and
//                raises tick for the cycle whose closing edge wraps the
//                count, so logic sampling tick on that edge acts exactly
//                once every TICK_DIV enabled cycles. No clock is derived.
//  Ports       : clk    system clock
//                rst_n  synchronous active-low reset (count -> 0)
//                en     1 = count, 0 = hold count, tick forced low
//                tick   combinational strobe from the registered count
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  en,
    output logic tick
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] c_cnt_max = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    generate
        if (TICK_DIV < 2) begin : g_tick_div_check
            $fatal(1, "tick_gen: TICK_DIV must be at least 2");
        end
    endgenerate

    assign w_wrap = en && (r_cnt == c_cnt_max);
    assign tick   = w_wrap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/traffic_light_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_sequencer
//  Description : Sequences one light RED -> GREEN -> YELLOW -> RED, each
//                phase lasting a parameterised number of 1-second ticks.
//                A latched pedestrian request trims GREEN to at most
//                PED_GREEN ticks and is acknowledged on RED entry.
//  Ports       : clk    system clock, all logic on posedge
//                rst_n  synchronous active-low reset
//                bus    traffic_light_sequencer_if.slave
//                       (en, ped_req in; ped_ack, lamps, state, remain,
//                        sec_tick out)
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_sequencer
    import tl_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int RED_T     = 10,
    parameter int GREEN_T   = 8,
    parameter int YELLOW_T  = 2,
    parameter int PED_GREEN = 3,
    parameter int CNT_W     = 8
) (
    input  wire                        clk,
    input  wire                        rst_n,
    traffic_light_sequencer_if.slave   bus
);
    localparam logic [CNT_W-1:0] c_red_t     = CNT_W'(RED_T);
    localparam logic [CNT_W-1:0] c_green_t   = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] c_yellow_t  = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] c_ped_green = CNT_W'(PED_GREEN);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
    localparam longint           c_cnt_lim   = (64'd1 << CNT_W) - 64'd1;

    // Every duration must fit in remain without truncation.
    generate
        if ((RED_T > c_cnt_lim) || (GREEN_T > c_cnt_lim) ||
            (YELLOW_T > c_cnt_lim) || (PED_GREEN > c_cnt_lim)) begin : g_cnt_w_check
            $fatal(1, "traffic_light_sequencer: CNT_W too small for a duration");
        end
        if ((RED_T < 1) || (GREEN_T < 1) || (YELLOW_T < 1) || (PED_GREEN < 1)) begin : g_dur_check
            $fatal(1, "traffic_light_sequencer: durations must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Tick source
    // ------------------------------------------------------------------
    logic w_tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tl_state_e        r_state;
    logic [CNT_W-1:0] r_remain;
    logic             r_ped_pending;
    logic             r_ped_ack;
    logic             r_sec_tick;
    tl_lamps_t        r_lamps;

    tl_state_e        w_state_nxt;
    logic [CNT_W-1:0] w_remain_nxt;
    logic             w_pending_nxt;
    logic             w_ack_nxt;
    logic             w_enter_red;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RED;
            r_remain      <= c_red_t;
            r_ped_pending <= 1'b0;
            r_ped_ack     <= 1'b0;
            r_sec_tick    <= 1'b0;
            r_lamps       <= lamp_decode(ST_RED);
        end else begin
            r_state       <= w_state_nxt;
            r_remain      <= w_remain_nxt;
            r_ped_pending <= w_pending_nxt;
            r_ped_ack     <= w_ack_nxt;
            r_sec_tick    <= w_tick;
            // Lamps decoded from the next phase so they change on the same
            // edge as state while still coming straight from flops.
            r_lamps       <= lamp_decode(w_state_nxt);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_remain_nxt  = r_remain;
        w_pending_nxt = r_ped_pending;
        w_ack_nxt     = 1'b0;
        w_enter_red   = 1'b0;

        // Phase timer
        if (r_state == ST_ILLEGAL) begin
            // Recover immediately, independent of en and the tick.
            w_state_nxt  = ST_RED;
            w_remain_nxt = c_red_t;
        end else if (w_tick) begin
            if (r_remain > c_one) begin
                // Pedestrian trim takes the place of the normal decrement.
                if ((r_state == ST_GREEN) && r_ped_pending && (r_remain > c_ped_green)) begin
                    w_remain_nxt = c_ped_green;
                end else begin
                    w_remain_nxt = r_remain - c_one;
                end
            end else begin
                case (r_state)
                    ST_RED: begin
                        w_state_nxt  = ST_GREEN;
                        w_remain_nxt = c_green_t;
                    end
                    ST_GREEN: begin
                        w_state_nxt  = ST_YELLOW;
                        w_remain_nxt = c_yellow_t;
                    end
                    ST_YELLOW: begin
                        w_state_nxt  = ST_RED;
                        w_remain_nxt = c_red_t;
                        w_enter_red  = 1'b1;
                    end
                    default: begin
                        w_state_nxt  = ST_RED;
                        w_remain_nxt = c_red_t;
                    end
                endcase
            end
        end

        // Pedestrian latch. Recovery from the illegal code is not a served
        // crossing, so any request is dropped silently there.
        if (r_state == ST_ILLEGAL) begin
            w_pending_nxt = 1'b0;
        end else if (w_enter_red && r_ped_pending) begin
            w_ack_nxt     = 1'b1;
            w_pending_nxt = 1'b0;
        end else if (bus.ped_req && (r_state != ST_RED)) begin
            w_pending_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.state    = r_state;
    assign bus.remain   = r_remain;
    assign bus.ped_ack  = r_ped_ack;
    assign bus.sec_tick = r_sec_tick;
    assign bus.red      = r_lamps.red;
    assign bus.yellow   = r_lamps.yellow;
    assign bus.green    = r_lamps.green;
endmodule
`default_nettype wire

// File: tb/tb_traffic_light_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_sequencer
//  Description : Directed self-checking bench for traffic_light_sequencer
//                with TICK_DIV=4, RED_T=3, GREEN_T=4, YELLOW_T=2,
//                PED_GREEN=2. Edge numbers count posedges after reset
//                release (E1 is the first edge with rst_n=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_sequencer;
    import tl_pkg::*;

    localparam int TICK_DIV  = 4;
    localparam int RED_T     = 3;
    localparam int GREEN_T   = 4;
    localparam int YELLOW_T  = 2;
    localparam int PED_GREEN = 2;
    localparam int CNT_W     = 8;

    logic clk;
    logic rst_n;

    traffic_light_sequencer_if #(.CNT_W(CNT_W)) bus ();

    traffic_light_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .RED_T     (RED_T),
        .GREEN_T   (GREEN_T),
        .YELLOW_T  (YELLOW_T),
        .PED_GREEN (PED_GREEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int edge_k;
    int ack_cnt;
    int tick_cnt;
    int onehot_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n posedges, ending on the following negedge; tally events.
    task automatic adv(input int n);
        repeat (n) begin
            @(negedge clk);
            edge_k++;
            if (bus.ped_ack)  ack_cnt++;
            if (bus.sec_tick) tick_cnt++;
            if (!$onehot({bus.red, bus.yellow, bus.green})) onehot_err++;
        end
    endtask

    // Two reset edges, then release; leaves the bench just before E1.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        edge_k     = 0;
        ack_cnt    = 0;
        tick_cnt   = 0;
        onehot_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        edge_k      = 0;
        ack_cnt     = 0;
        tick_cnt    = 0;
        onehot_err  = 0;
        rst_n       = 1'b0;
        bus.en      = 1'b1;
        bus.ped_req = 1'b0;

        // ---------------- 1. reset state, first tick ----------------
        do_reset();
        check("rst_red",     {31'd0, bus.red},    32'd1);
        check("rst_yellow",  {31'd0, bus.yellow}, 32'd0);
        check("rst_green",   {31'd0, bus.green},  32'd0);
        check("rst_state",   {30'd0, bus.state},  32'd0);
        check("rst_remain",  {24'd0, bus.remain}, 32'd3);
        check("rst_ped_ack", {31'd0, bus.ped_ack},  32'd0);
        check("rst_tick",    {31'd0, bus.sec_tick}, 32'd0);
        adv(3);
        check("no_tick_e3",  {31'd0, bus.sec_tick}, 32'd0);
        adv(1);
        check("tick_e4",     {31'd0, bus.sec_tick}, 32'd1);
        check("remain_e4",   {24'd0, bus.remain},   32'd2);
        adv(1);
        check("tick_e5_low", {31'd0, bus.sec_tick}, 32'd0);

        // ---------------- 2. free run timing ----------------
        while (!bus.green && edge_k < 100) adv(1);
        check("green_edge",   edge_k, 32'd12);
        check("green_remain", {24'd0, bus.remain}, 32'd4);
        check("green_state",  {30'd0, bus.state},  32'd1);
        while (!bus.yellow && edge_k < 100) adv(1);
        check("yellow_edge",  edge_k, 32'd28);
        check("yellow_state", {30'd0, bus.state}, 32'd2);
        while (!bus.red && edge_k < 100) adv(1);
        check("red_edge",     edge_k, 32'd36);
        check("red_remain",   {24'd0, bus.remain}, 32'd3);
        while (!bus.green && edge_k < 100) adv(1);
        check("green2_edge",  edge_k, 32'd48);
        check("onehot_run",   onehot_err, 32'd0);
        check("no_ack_run",   ack_cnt, 32'd0);

        // ---------------- 3. pedestrian shortens GREEN ----------------
        do_reset();
        adv(12);
        check("p_green", {31'd0, bus.green}, 32'd1);
        bus.ped_req = 1'b1;
        adv(1);
        bus.ped_req = 1'b0;
        check("p_remain_e13", {24'd0, bus.remain}, 32'd4);
        adv(3);
        check("p_remain_e16", {24'd0, bus.remain}, 32'd2);
        adv(4);
        check("p_remain_e20", {24'd0, bus.remain}, 32'd1);
        adv(4);
        check("p_yellow_e24", {31'd0, bus.yellow}, 32'd1);
        check("p_ack_before", ack_cnt, 32'd0);
        adv(7);
        check("p_ack_e31", {31'd0, bus.ped_ack}, 32'd0);
        adv(1);
        check("p_red_e32", {31'd0, bus.red},     32'd1);
        check("p_ack_e32", {31'd0, bus.ped_ack}, 32'd1);
        adv(1);
        check("p_ack_e33", {31'd0, bus.ped_ack}, 32'd0);
        adv(20);
        check("p_ack_total", ack_cnt, 32'd1);

        // ---------------- 4. en=0 mid-YELLOW ----------------
        do_reset();
        adv(30);
        check("f_yellow_e30", {31'd0, bus.yellow}, 32'd1);
        bus.en   = 1'b0;
        tick_cnt = 0;
        adv(10);
        bus.en   = 1'b1;
        check("f_no_tick",  tick_cnt, 32'd0);
        check("f_remain",   {24'd0, bus.remain}, 32'd2);
        check("f_yellow",   {31'd0, bus.yellow}, 32'd1);
        check("f_cnt",      {30'd0, dut.u_tick_gen.r_cnt}, 32'd2);
        adv(2);
        check("f_remain_e42", {24'd0, bus.remain}, 32'd1);
        while (!bus.red && edge_k < 100) adv(1);
        check("f_red_edge", edge_k, 32'd46);

        // ---------------- 5. reset drops a pending request ----------------
        do_reset();
        adv(12);
        bus.ped_req = 1'b1;
        adv(1);
        bus.ped_req = 1'b0;
        adv(1);
        check("r_pending_set", {31'd0, dut.r_ped_pending}, 32'd1);
        rst_n = 1'b0;
        adv(1);
        check("r_red",    {31'd0, bus.red},    32'd1);
        check("r_remain", {24'd0, bus.remain}, 32'd3);
        rst_n   = 1'b1;
        edge_k  = 0;
        ack_cnt = 0;
        adv(40);
        check("r_red_again", {31'd0, bus.red}, 32'd1);
        check("r_no_ack",    ack_cnt, 32'd0);

        // ---------------- 6. request during RED ignored; illegal code ----------------
        do_reset();
        bus.ped_req = 1'b1;
        while (!bus.green && edge_k < 100) adv(1);
        bus.ped_req = 1'b0;
        check("i_green_edge", edge_k, 32'd12);
        check("i_no_pending", {31'd0, dut.r_ped_pending}, 32'd0);
        while (!bus.yellow && edge_k < 100) adv(1);
        check("i_yellow_edge", edge_k, 32'd28);
        adv(13);
        check("i_remain_e41", {24'd0, bus.remain}, 32'd2);
        check("i_no_ack",     ack_cnt, 32'd0);
        force dut.r_state = ST_ILLEGAL;
        #1;
        release dut.r_state;
        check("i_state_3", {30'd0, bus.state}, 32'd3);
        adv(1);
        check("i_state_red",  {30'd0, bus.state},  32'd0);
        check("i_red_lamp",   {31'd0, bus.red},    32'd1);
        check("i_remain_rst", {24'd0, bus.remain}, 32'd3);
        check("i_ack_none",   {31'd0, bus.ped_ack}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
